// File: rtl/regfile_write_ctrl.sv
// ---------------------------------------------------------------------------
// regfile_write_ctrl
//
// Write-port controller for a register file that has no reset of its own.
// After reset it walks every register once, writing INIT_VALUE. It then
// shares the single write port between the ALU writeback and load writeback
// requesters with valid/ready handshakes and round-robin tie-breaking.
//
// Write-port outputs are registered and feed the register file directly.
// An edge with writeEnable=0 corrupts the addressed entry, so every idle
// cycle parks the address on PARK_ADDR (the hardwired-zero register).
//
// Ports:
//   clk          clock, all state on the rising edge
//   reset        synchronous, active-high reset
//   alu_valid    ALU writeback request
//   alu_addr     ALU destination register
//   alu_data     ALU result
//   alu_ready    ALU request accepted this cycle (combinational)
//   mem_valid    load writeback request
//   mem_addr     load destination register
//   mem_data     load data
//   mem_ready    load request accepted this cycle (combinational)
//   writeAddr    register file write address (registered)
//   writeData    register file write data (registered)
//   writeEnable  register file write enable (registered)
//   init_done    high once the clear sequence is complete (registered)
//   conflict_cnt saturating count of contested RUN cycles, 16 bits
//                (only present when WRCTL_CONFLICT_CNT_EN is defined)
//
// Optional feature macro: WRCTL_CONFLICT_CNT_EN
// ---------------------------------------------------------------------------
module regfile_write_ctrl #(
    parameter int unsigned       NUM_REGS   = 32,
    parameter int unsigned       ADDR_W     = 5,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    parameter logic [ADDR_W-1:0] PARK_ADDR  = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              alu_valid,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] writeAddr,
    output logic [DATA_W-1:0] writeData,
    output logic              writeEnable,
    output logic              init_done
`ifdef WRCTL_CONFLICT_CNT_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    // Counter must be able to hold NUM_REGS itself: that value marks the
    // cycle in which the last clear write lands in the register file.
    localparam int unsigned CNT_W = $clog2(NUM_REGS + 1);
    localparam logic [CNT_W-1:0] CLR_END = CNT_W'(NUM_REGS);

    // Round-robin memory: which requester won the most recent contested cycle.
    localparam logic RR_ALU = 1'b0;
    localparam logic RR_MEM = 1'b1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    clr_cnt_q, clr_cnt_d;
    logic                rr_last_q, rr_last_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                init_done_q, init_done_d;

    logic                run_active;
    logic                both_valid;
    logic                accept;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            clr_cnt_q   <= '0;
            rr_last_q   <= RR_MEM;
            we_q        <= 1'b0;
            waddr_q     <= PARK_ADDR;
            wdata_q     <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            rr_last_q   <= rr_last_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            init_done_q <= init_done_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // RUN is entered once the counter has passed the last register, i.e.
    // on the edge where the final clear write is consumed by the regfile.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_INIT && clr_cnt_q == CLR_END) begin
            state_d = ST_RUN;
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath logic
    // ------------------------------------------------------------------
    assign run_active = (state_q == ST_RUN) && !reset;
    assign both_valid = alu_valid && mem_valid;

    // On a tie the requester that did not win last time is granted.
    assign alu_ready = run_active && alu_valid && (!mem_valid || rr_last_q == RR_MEM);
    assign mem_ready = run_active && mem_valid && (!alu_valid || rr_last_q == RR_ALU);

    assign accept   = alu_ready || mem_ready;
    assign sel_addr = alu_ready ? alu_addr : mem_addr;
    assign sel_data = alu_ready ? alu_data : mem_data;

    always_comb begin
        clr_cnt_d   = clr_cnt_q;
        rr_last_d   = rr_last_q;
        we_d        = 1'b0;
        waddr_d     = PARK_ADDR;
        wdata_d     = wdata_q;
        init_done_d = init_done_q;

        if (state_q == ST_INIT) begin
            if (clr_cnt_q != CLR_END) begin
                we_d      = 1'b1;
                waddr_d   = ADDR_W'(clr_cnt_q);
                wdata_d   = INIT_VALUE;
                clr_cnt_d = clr_cnt_q + 1'b1;
            end else begin
                init_done_d = 1'b1;
            end
        end else begin
            // Only contested cycles move the round-robin pointer.
            if (both_valid) begin
                rr_last_d = alu_ready ? RR_ALU : RR_MEM;
            end
            // Register 0 is hardwired: the handshake completes but the
            // write is suppressed and the port stays parked.
            if (accept && sel_addr != '0) begin
                we_d    = 1'b1;
                waddr_d = sel_addr;
                wdata_d = sel_data;
            end
        end
    end

    assign writeEnable = we_q;
    assign writeAddr   = waddr_q;
    assign writeData   = wdata_q;
    assign init_done   = init_done_q;

`ifdef WRCTL_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (state_q == ST_RUN && both_valid && conflict_cnt_q != 16'hFFFF) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_ctrl
//
// Self-checking bench for regfile_write_ctrl. A behavioural reference model
// predicts ready outputs and the registered write port from the number of
// cycles since reset release, a "who goes first on a tie" flag, and an array
// standing in for the register file contents.
// ---------------------------------------------------------------------------
module tb_regfile_write_ctrl;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alu_valid = 1'b0;
    logic [AW-1:0] alu_addr = '0;
    logic [DW-1:0] alu_data = '0;
    logic          alu_ready;
    logic          mem_valid = 1'b0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_data = '0;
    logic          mem_ready;
    logic [AW-1:0] writeAddr;
    logic [DW-1:0] writeData;
    logic          writeEnable;
    logic          init_done;
`ifdef WRCTL_CONFLICT_CNT_EN
    logic [15:0]   conflict_cnt;
`endif

    regfile_write_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .alu_valid   (alu_valid),
        .alu_addr    (alu_addr),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .mem_valid   (mem_valid),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready),
        .writeAddr   (writeAddr),
        .writeData   (writeData),
        .writeEnable (writeEnable),
        .init_done   (init_done)
`ifdef WRCTL_CONFLICT_CNT_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model state
    int            m_since_rel = 0;   // clock edges since reset was released
    bit            m_alu_first = 1'b1;
    logic          m_we = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0;
    logic          m_done = 1'b0;
    logic [15:0]   m_conf = '0;
    logic [DW-1:0] m_rf [NR];         // expected register file contents
    logic [DW-1:0] d_rf [NR];         // contents as written by the DUT

    // Requester state for randomized traffic (held until accepted)
    bit            a_pend = 1'b0;
    logic [AW-1:0] a_addr_r = '0;
    logic [DW-1:0] a_data_r = '0;
    bit            m_pend = 1'b0;
    logic [AW-1:0] m_addr_r = '0;
    logic [DW-1:0] m_data_r = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check readys, advance model, check outputs.
    task automatic step(input logic rst,
                        input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                        output bit a_acc, output bit m_acc);
        bit            run;
        bit            ea;
        bit            em;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        reset     = rst;
        alu_valid = av;
        alu_addr  = aa;
        alu_data  = ad;
        mem_valid = mv;
        mem_addr  = ma;
        mem_data  = md;
        #1;
        run = !rst && (m_since_rel > NR);
        ea  = run && av && (!mv || m_alu_first);
        em  = run && mv && (!av || !m_alu_first);
        chk("alu_ready", 32'(alu_ready), 32'(ea));
        chk("mem_ready", 32'(mem_ready), 32'(em));
        a_acc = ea;
        m_acc = em;

        if (rst) begin
            m_since_rel = 0;
            m_alu_first = 1'b1;
            m_we   = 1'b0;
            m_addr = '0;
            m_data = '0;
            m_done = 1'b0;
            m_conf = '0;
        end else if (!run) begin
            m_since_rel++;
            if (m_since_rel <= NR) begin
                m_we   = 1'b1;
                m_addr = AW'(m_since_rel - 1);
                m_data = '0;
                m_rf[m_since_rel - 1] = '0;
            end else begin
                m_we   = 1'b0;
                m_addr = '0;
                m_done = 1'b1;
            end
        end else begin
            if (av && mv) begin
                m_alu_first = !m_alu_first;
                if (m_conf != 16'hFFFF) m_conf = m_conf + 16'd1;
            end
            m_we   = 1'b0;
            m_addr = '0;
            if (ea || em) begin
                addr = ea ? aa : ma;
                data = ea ? ad : md;
                if (addr != '0) begin
                    m_we   = 1'b1;
                    m_addr = addr;
                    m_data = data;
                    m_rf[addr] = data;
                end
            end
        end

        @(posedge clk);
        #1;
        chk("writeEnable", 32'(writeEnable), 32'(m_we));
        chk("writeAddr", 32'(writeAddr), 32'(m_addr));
        chk("writeData", writeData, m_data);
        chk("init_done", 32'(init_done), 32'(m_done));
`ifdef WRCTL_CONFLICT_CNT_EN
        chk("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
`endif
        if (writeEnable === 1'b1) d_rf[writeAddr] = writeData;
        $display("[TB] t=%0t rst=%0b alu=%0b/%0d mem=%0b/%0d rdy=%0b%0b we=%0b addr=%0d data=%0h done=%0b",
                 $time, rst, av, aa, mv, ma, alu_ready, mem_ready, writeEnable, writeAddr, writeData, init_done);
    endtask

    // Randomized traffic: each requester issues new requests at random and
    // holds them until accepted.
    task automatic rand_cycles(input int n, input logic rst);
        bit a_acc;
        bit m_acc;
        for (int i = 0; i < n; i++) begin
            if (!a_pend && $urandom_range(0, 99) < 55) begin
                a_pend   = 1'b1;
                a_addr_r = AW'($urandom_range(0, 31));
                a_data_r = $urandom;
            end
            if (!m_pend && $urandom_range(0, 99) < 55) begin
                m_pend   = 1'b1;
                // Bias toward a few addresses so same-destination races occur.
                m_addr_r = ($urandom_range(0, 3) == 0) ? a_addr_r : AW'($urandom_range(0, 31));
                m_data_r = $urandom;
            end
            step(rst, a_pend, a_addr_r, a_data_r, m_pend, m_addr_r, m_data_r, a_acc, m_acc);
            if (a_acc) a_pend = 1'b0;
            if (m_acc) m_pend = 1'b0;
        end
    endtask

    initial begin
        bit a_acc;
        bit m_acc;
        bit hold;
        int acc_k;
        int we_cnt;
        logic [3:0] order;

        // Reset held for two cycles
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, a_acc, m_acc);
        step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, a_acc, m_acc);

        // Clear sequence, with an ALU request held from cycle 10 of INIT
        hold   = 1'b0;
        acc_k  = -1;
        we_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (k == 10) hold = 1'b1;
            step(1'b0, hold, 5'd9, 32'hA5A5_0009, 1'b0, '0, '0, a_acc, m_acc);
            if (k <= NR && writeEnable === 1'b1) we_cnt++;
            if (a_acc) begin
                hold  = 1'b0;
                acc_k = k;
            end
        end
        chk("init_we_count", 32'(we_cnt), 32'(NR));
        chk("init_accept_cycle", 32'(acc_k), 32'(NR + 1));

        // Single ALU write, then idle
        step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, a_acc, m_acc);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a_acc, m_acc);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a_acc, m_acc);

        // Both requesters contend for four cycles
        order = '0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0, 1'b1, 5'd3, 32'h0000_0333, 1'b1, 5'd7, 32'h0000_0777, a_acc, m_acc);
            order = {order[2:0], a_acc};
        end
        chk("tie_order", 32'(order), 32'h0000_000A);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a_acc, m_acc);

        // Load writeback to the zero register is accepted but not written
        step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_1234, a_acc, m_acc);
        chk("zero_reg_accept", 32'(m_acc), 32'd1);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, a_acc, m_acc);

        // Randomized RUN traffic
        rand_cycles(400, 1'b0);

        // Reset in the middle of the clear sequence
        rand_cycles(1, 1'b1);
        while (m_since_rel < 18) rand_cycles(1, 1'b0);
        chk("mid_init_addr17", 32'(writeAddr), 32'd17);
        rand_cycles(1, 1'b1);
        rand_cycles(45, 1'b0);
        rand_cycles(300, 1'b0);

        // Drain outstanding requests
        for (int k = 0; k < 4; k++) begin
            step(1'b0, a_pend, a_addr_r, a_data_r, m_pend, m_addr_r, m_data_r, a_acc, m_acc);
            if (a_acc) a_pend = 1'b0;
            if (m_acc) m_pend = 1'b0;
        end

        // Register file contents (register 0 is hardwired, not compared)
        for (int r = 1; r < NR; r++) begin
            chk($sformatf("rf[%0d]", r), d_rf[r], m_rf[r]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
